// File: rtl/z80_bus_pin_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_pin_sequencer_if
// Brief    : Core-side and pin-side signal bundle for the Z80 pin sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface z80_bus_pin_sequencer_if;
  logic        ena;
  logic [15:0] core_addr;
  logic [7:0]  core_dout;
  logic [7:0]  core_ctrl_n;
  logic [7:0]  core_din;
  logic        core_cen;
  logic [3:0]  core_in_n;
  logic [7:0]  pin_out;
  logic [7:0]  pin_io_in;
  logic [7:0]  pin_io_out;
  logic [7:0]  pin_io_oe;
  logic [3:0]  pin_ctl_in;

  // master drives the core outputs and the pins; slave is the sequencer
  modport master (
    output ena, core_addr, core_dout, core_ctrl_n, pin_io_in, pin_ctl_in,
    input  core_din, core_cen, core_in_n, pin_out, pin_io_out, pin_io_oe
  );

  modport slave (
    input  ena, core_addr, core_dout, core_ctrl_n, pin_io_in, pin_ctl_in,
    output core_din, core_cen, core_in_n, pin_out, pin_io_out, pin_io_oe
  );
endinterface
`default_nettype wire

// File: rtl/z80_bus_pin_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : z80_bus_pin_sequencer
// Brief    : 4-phase frame that multiplexes Z80 address/data/strobes onto pins
//            and paces the core through a clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module z80_bus_pin_sequencer (
  input  wire logic               clk,
  input  wire logic               reset,
  z80_bus_pin_sequencer_if.slave  bus
);

  localparam logic [1:0] c_P0 = 2'd0;
  localparam logic [1:0] c_P1 = 2'd1;
  localparam logic [1:0] c_P2 = 2'd2;
  localparam logic [1:0] c_P3 = 2'd3;

  localparam int c_BIT_MREQ = 6;
  localparam int c_BIT_IORQ = 5;
  localparam int c_BIT_RD   = 4;
  localparam int c_BIT_WR   = 3;

  logic [1:0]  r_phase;
  logic [1:0]  w_phase_nxt;

  logic [15:0] r_s_addr;
  logic [7:0]  r_s_dout;
  logic [7:0]  r_s_ctrl;
  logic [7:0]  r_core_din;
  logic [3:0]  r_core_in_n;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;

  logic [7:0]  w_pin_out;
  logic [7:0]  w_pin_io_out;
  logic [7:0]  w_pin_io_oe;
  logic        w_core_cen;
  logic        w_wr;
  logic        w_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase <= c_P0;
    end else begin
      r_phase <= w_phase_nxt;
    end
  end

  // A stalled frame simply wraps back to P0; only ena can hold the phase.
  always_comb begin
    w_phase_nxt = r_phase;
    if (bus.ena) begin
      w_phase_nxt = r_phase + 2'd1;
    end
  end

  assign w_wr = !r_s_ctrl[c_BIT_WR] && (!r_s_ctrl[c_BIT_MREQ] || !r_s_ctrl[c_BIT_IORQ]);
  assign w_rd = !r_s_ctrl[c_BIT_RD];

  always_comb begin
    w_pin_out    = r_s_ctrl;
    w_pin_io_out = 8'h00;
    w_pin_io_oe  = 8'h00;
    w_core_cen   = 1'b0;
    case (r_phase)
      c_P1:    w_pin_out = r_s_addr[7:0];
      c_P2:    w_pin_out = r_s_addr[15:8];
      default: w_pin_out = r_s_ctrl;
    endcase
    if (w_wr) begin
      w_pin_io_out = r_s_dout;
      w_pin_io_oe  = 8'hFF;
    end
    w_core_cen = (r_phase == c_P3) && bus.ena && r_core_in_n[0] && !reset;
  end

  // The synchronizer keeps running while the tile is deselected.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= bus.pin_ctl_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_addr    <= 16'h0000;
      r_s_dout    <= 8'h00;
      r_s_ctrl    <= 8'hFF;
      r_core_din  <= 8'h00;
      r_core_in_n <= 4'hF;
    end else if (bus.ena) begin
      if (r_phase == c_P0) begin
        r_s_addr <= bus.core_addr;
        r_s_dout <= bus.core_dout;
        r_s_ctrl <= bus.core_ctrl_n;
      end
      if (r_phase == c_P2) begin
        r_core_in_n <= r_sync2;
        if (w_rd) begin
          r_core_din <= bus.pin_io_in;
        end
      end
    end
  end

  assign bus.pin_out    = w_pin_out;
  assign bus.pin_io_out = w_pin_io_out;
  assign bus.pin_io_oe  = w_pin_io_oe;
  assign bus.core_cen   = w_core_cen;
  assign bus.core_din   = r_core_din;
  assign bus.core_in_n  = r_core_in_n;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_pin_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_z80_bus_pin_sequencer
// Brief    : Directed vector table plus stall-release sequence for the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_z80_bus_pin_sequencer;

  logic clk;
  logic reset;

  z80_bus_pin_sequencer_if bus ();

  z80_bus_pin_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  ctrl;
    logic [7:0]  io_in;
    logic [3:0]  ctl;
    logic [7:0]  e_pin;
    logic [7:0]  e_oe;
    logic [7:0]  e_io;
    logic        e_cen;
    logic [7:0]  e_din;
    logic [3:0]  e_inn;
  } vec_t;

  vec_t vq[$];
  int   n_cmp;
  int   n_bad;

  function automatic vec_t mk(
    input logic rst, input logic en, input logic [15:0] addr, input logic [7:0] dout,
    input logic [7:0] ctrl, input logic [7:0] io_in, input logic [3:0] ctl,
    input logic [7:0] e_pin, input logic [7:0] e_oe, input logic [7:0] e_io,
    input logic e_cen, input logic [7:0] e_din, input logic [3:0] e_inn);
    vec_t v;
    v.rst = rst; v.en = en; v.addr = addr; v.dout = dout; v.ctrl = ctrl;
    v.io_in = io_in; v.ctl = ctl; v.e_pin = e_pin; v.e_oe = e_oe; v.e_io = e_io;
    v.e_cen = e_cen; v.e_din = e_din; v.e_inn = e_inn;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cen_hits;
    n_cmp = 0;
    n_bad = 0;

    //        rst en addr     dout   ctrl   io     ctl  | pin    oe     io     cen   din    inn
    vq.push_back(mk(1, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    // frame 0: reset snapshot on the pins
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 4'hF));
    // frame 1: mux order
    vq.push_back(mk(0, 1, 16'h1234, 8'h00, 8'h3F, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h1234, 8'h00, 8'h3F, 8'h00, 4'hF, 8'h34, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h1234, 8'h00, 8'h3F, 8'h00, 4'hF, 8'h12, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h1234, 8'h00, 8'h3F, 8'h00, 4'hF, 8'h3F, 8'h00, 8'h00, 1'b1, 8'h00, 4'hF));
    // frame 2: memory write
    vq.push_back(mk(0, 1, 16'h8000, 8'hA5, 8'hB7, 8'h00, 4'hF, 8'h3F, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h8000, 8'hA5, 8'hB7, 8'h00, 4'hF, 8'h00, 8'hFF, 8'hA5, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h8000, 8'hA5, 8'hB7, 8'h00, 4'hF, 8'h80, 8'hFF, 8'hA5, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h8000, 8'hA5, 8'hB7, 8'h00, 4'hF, 8'hB7, 8'hFF, 8'hA5, 1'b1, 8'h00, 4'hF));
    // frame 3: memory read, data only valid in P2; wait_n drops in P3
    vq.push_back(mk(0, 1, 16'h4321, 8'h11, 8'hAF, 8'h00, 4'hF, 8'hB7, 8'hFF, 8'hA5, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h4321, 8'h11, 8'hAF, 8'h00, 4'hF, 8'h21, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h4321, 8'h11, 8'hAF, 8'h5A, 4'hF, 8'h43, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h4321, 8'h11, 8'hAF, 8'h00, 4'hE, 8'hAF, 8'h00, 8'h00, 1'b1, 8'h5A, 4'hF));
    // frame 4: first stalled frame
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'hAF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    // frame 5: release comes too late for this P2 sample
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hE, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    // frame 6: resumes
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hE));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h5A, 4'hF));
    // frame 7: read frame frozen for 5 cycles in P2, then 2 cycles in P3
    vq.push_back(mk(0, 1, 16'hBEEF, 8'h00, 8'hAF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 1, 16'hBEEF, 8'h00, 8'hAF, 8'h00, 4'hF, 8'hEF, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0, 0, 16'hBEEF, 8'h00, 8'hAF, 8'h77, 4'hF, 8'hBE, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 1, 16'hBEEF, 8'h00, 8'hAF, 8'h99, 4'hF, 8'hBE, 8'h00, 8'h00, 1'b0, 8'h5A, 4'hF));
    vq.push_back(mk(0, 0, 16'hBEEF, 8'h00, 8'hAF, 8'h00, 4'hF, 8'hAF, 8'h00, 8'h00, 1'b0, 8'h99, 4'hF));
    vq.push_back(mk(0, 0, 16'hBEEF, 8'h00, 8'hAF, 8'h00, 4'hF, 8'hAF, 8'h00, 8'h00, 1'b0, 8'h99, 4'hF));
    vq.push_back(mk(0, 1, 16'hBEEF, 8'h00, 8'hAF, 8'h00, 4'hF, 8'hAF, 8'h00, 8'h00, 1'b1, 8'h99, 4'hF));
    // frame 8: write snapshot, then reset with ena=0 in P1
    vq.push_back(mk(0, 1, 16'h5566, 8'h3C, 8'hB7, 8'h00, 4'hF, 8'hAF, 8'h00, 8'h00, 1'b0, 8'h99, 4'hF));
    vq.push_back(mk(1, 0, 16'h5566, 8'h3C, 8'hB7, 8'h00, 4'hF, 8'h66, 8'hFF, 8'h3C, 1'b0, 8'h99, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4'hF));
    vq.push_back(mk(0, 1, 16'h0000, 8'h00, 8'hFF, 8'h00, 4'hF, 8'hFF, 8'h00, 8'h00, 1'b1, 8'h00, 4'hF));

    reset           = 1'b1;
    bus.ena         = 1'b1;
    bus.core_addr   = 16'h0000;
    bus.core_dout   = 8'h00;
    bus.core_ctrl_n = 8'hFF;
    bus.pin_io_in   = 8'h00;
    bus.pin_ctl_in  = 4'hF;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset           = vq[i].rst;
      bus.ena         = vq[i].en;
      bus.core_addr   = vq[i].addr;
      bus.core_dout   = vq[i].dout;
      bus.core_ctrl_n = vq[i].ctrl;
      bus.pin_io_in   = vq[i].io_in;
      bus.pin_ctl_in  = vq[i].ctl;
      #1;
      check("pin_out",    i, {8'h00, bus.pin_out},    {8'h00, vq[i].e_pin});
      check("pin_io_oe",  i, {8'h00, bus.pin_io_oe},  {8'h00, vq[i].e_oe});
      check("pin_io_out", i, {8'h00, bus.pin_io_out}, {8'h00, vq[i].e_io});
      check("core_cen",   i, {15'h0, bus.core_cen},   {15'h0, vq[i].e_cen});
      check("core_din",   i, {8'h00, bus.core_din},   {8'h00, vq[i].e_din});
      check("core_in_n",  i, {12'h0, bus.core_in_n},  {12'h0, vq[i].e_inn});
    end

    // Long WAIT from the first frame after reset; snapshot keeps reloading.
    @(negedge clk);
    reset           = 1'b1;
    bus.ena         = 1'b1;
    bus.core_addr   = 16'h2468;
    bus.core_ctrl_n = 8'hFF;
    bus.pin_ctl_in  = 4'hF;
    @(negedge clk);
    reset          = 1'b0;
    bus.pin_ctl_in = 4'hE;
    cen_hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.core_cen) cen_hits++;
      if (i == 9) check("stall_p1_addr", i, {8'h00, bus.pin_out}, 16'h0068);
    end
    check("stall_cen_count", 0, cen_hits[15:0], 16'd0);

    @(negedge clk);
    bus.pin_ctl_in = 4'hF;
    k = 0;
    #1;
    while (!bus.core_cen && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (k >= 20) begin
      n_cmp++;
      n_bad++;
      $display("FAIL release_timeout: core_cen not seen within 20 cycles (required 3)");
    end else begin
      check("release_latency", 0, k[15:0], 16'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
